// File: rtl/fast_map_sram_arbiter.sv
// Round-robin req/gnt arbiter sharing the single-port FAST-map SRAM between the
// corner-score writer and the circle drawer, with registered commands and read return.
module fast_map_sram_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_x,
    input  logic [ADDR_W-1:0] wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_x,
    input  logic [ADDR_W-1:0] rd_y,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_we,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_x,
    output logic [ADDR_W-1:0] sram_y,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              idle
);

    typedef enum logic {
        PREF_WR = 1'b0,
        PREF_RD = 1'b1
    } arb_state_e;

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT:0]   vpipe_ext;

    // Arbitration state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= PREF_WR;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decode; grants are suppressed while reset is asserted
    always_comb begin
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        state_nxt = state;
        if (n_rst) begin
            case (state)
                PREF_WR: begin
                    if (wr_req) begin
                        wr_gnt    = 1'b1;
                        state_nxt = PREF_RD;
                    end else if (rd_req) begin
                        rd_gnt    = 1'b1;
                        state_nxt = PREF_WR;
                    end
                end
                PREF_RD: begin
                    if (rd_req) begin
                        rd_gnt    = 1'b1;
                        state_nxt = PREF_WR;
                    end else if (wr_req) begin
                        wr_gnt    = 1'b1;
                        state_nxt = PREF_RD;
                    end
                end
                default: state_nxt = PREF_WR;
            endcase
        end
    end

    // Registered SRAM command; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sram_we    <= 1'b0;
            sram_re    <= 1'b0;
            sram_x     <= '0;
            sram_y     <= '0;
            sram_wdata <= '0;
        end else begin
            sram_we <= wr_gnt;
            sram_re <= rd_gnt;
            if (wr_gnt) begin
                sram_x     <= wr_x;
                sram_y     <= wr_y;
                sram_wdata <= wr_data;
            end else if (rd_gnt) begin
                sram_x <= rd_x;
                sram_y <= rd_y;
            end
        end
    end

    // Top bit of the extended vector is the pipe tail: SRAM data is valid this cycle
    assign vpipe_ext = {vpipe, sram_re};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vpipe    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            idle     <= 1'b1;
        end else begin
            vpipe    <= vpipe_ext[RD_LAT-1:0];
            rd_valid <= vpipe_ext[RD_LAT];
            if (vpipe_ext[RD_LAT]) begin
                rd_data <= sram_rdata;
            end
            idle <= !wr_gnt && !rd_gnt && !sram_re && (vpipe == '0);
        end
    end

endmodule

// File: tb/tb_fast_map_sram_arbiter.sv
// Directed bench for fast_map_sram_arbiter: two instances (RD_LAT=1 and 3) share the
// requester stimulus; a grant-order scoreboard checks commands, read data and latency.
module tb_fast_map_sram_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        logic d;
        int   cyc;
    } rd_item_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       wr_req, rd_req;
    logic [3:0] wr_x, wr_y, rd_x, rd_y;
    logic       wr_data;

    logic       wg0, rg0, rv0, rdd0, we0, re0, wd0, rdat0, idl0;
    logic [3:0] sx0, sy0;
    logic       wg1, rg1, rv1, rdd1, we1, re1, wd1, rdat1, idl1;
    logic [3:0] sx1, sy1;

    always #5 clk = ~clk;

    fast_map_sram_arbiter #(.ADDR_W(4), .DATA_W(1), .RD_LAT(LAT0)) dut0 (
        .clk(clk), .n_rst(n_rst),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wg0),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rg0),
        .rd_valid(rv0), .rd_data(rdd0),
        .sram_we(we0), .sram_re(re0), .sram_x(sx0), .sram_y(sy0), .sram_wdata(wd0),
        .sram_rdata(rdat0), .idle(idl0)
    );

    fast_map_sram_arbiter #(.ADDR_W(4), .DATA_W(1), .RD_LAT(LAT1)) dut1 (
        .clk(clk), .n_rst(n_rst),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wg1),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rg1),
        .rd_valid(rv1), .rd_data(rdd1),
        .sram_we(we1), .sram_re(re1), .sram_x(sx1), .sram_y(sy1), .sram_wdata(wd1),
        .sram_rdata(rdat1), .idle(idl1)
    );

    // SRAM models: one-cycle read access followed by (latency-1) output stages
    bit mem0 [256];
    bit dp0;
    always @(posedge clk) begin
        if (we0) mem0[{sx0, sy0}] <= wd0;
        dp0 <= re0 ? mem0[{sx0, sy0}] : 1'b0;
    end
    assign rdat0 = dp0;

    bit mem1 [256];
    bit dp1 [3];
    always @(posedge clk) begin
        if (we1) mem1[{sx1, sy1}] <= wd1;
        dp1[0] <= re1 ? mem1[{sx1, sy1}] : 1'b0;
        dp1[1] <= dp1[0];
        dp1[2] <= dp1[1];
    end
    assign rdat1 = dp1[2];

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         ref_mem [256];
    rd_item_t   rq [2][$];
    logic       pref_wr = 1'b1;
    logic       exp_we = 1'b0, exp_re = 1'b0, exp_wd = 1'b0;
    logic [3:0] exp_x = '0, exp_y = '0;
    logic       last_gw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_inst(input int k, input logic we, input logic re, input logic [3:0] sx,
                              input logic [3:0] sy, input logic wd, input logic rv,
                              input logic rdd, input logic idl);
        logic exp_rv;
        string p;
        rd_item_t it;
        p = (k == 0) ? "u0" : "u1";
        chk({p, "_sram_we"}, 32'(we), 32'(exp_we));
        chk({p, "_sram_re"}, 32'(re), 32'(exp_re));
        if (exp_we || exp_re) begin
            chk({p, "_sram_x"}, 32'(sx), 32'(exp_x));
            chk({p, "_sram_y"}, 32'(sy), 32'(exp_y));
        end
        if (exp_we) chk({p, "_sram_wdata"}, 32'(wd), 32'(exp_wd));
        chk({p, "_idle"}, 32'(idl), 32'(!exp_we && (rq[k].size() == 0)));
        exp_rv = (rq[k].size() > 0) && (rq[k][0].cyc <= cyc);
        chk({p, "_rd_valid"}, 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
            it = rq[k].pop_front();
            chk({p, "_rd_data"}, 32'(rdd), 32'(it.d));
        end
    endtask

    // One clock: check grants against the arbitration model, record expectations, advance
    task automatic cycle();
        logic gw, gr;
        rd_item_t it;
        #1;
        gw = n_rst && wr_req && (!rd_req || pref_wr);
        gr = n_rst && rd_req && !gw;
        chk("u0_wr_gnt", 32'(wg0), 32'(gw));
        chk("u0_rd_gnt", 32'(rg0), 32'(gr));
        chk("u1_wr_gnt", 32'(wg1), 32'(gw));
        chk("u1_rd_gnt", 32'(rg1), 32'(gr));
        last_gw = gw;
        @(posedge clk);
        cyc++;
        exp_we = gw;
        exp_re = gr;
        if (gw) begin
            exp_x  = wr_x;
            exp_y  = wr_y;
            exp_wd = wr_data;
            ref_mem[{wr_x, wr_y}] = wr_data;
            pref_wr = 1'b0;
        end else if (gr) begin
            exp_x = rd_x;
            exp_y = rd_y;
            it.d = ref_mem[{rd_x, rd_y}];
            it.cyc = cyc - 1 + LAT0 + 2;
            rq[0].push_back(it);
            it.cyc = cyc - 1 + LAT1 + 2;
            rq[1].push_back(it);
            pref_wr = 1'b1;
        end
        @(negedge clk);
        check_inst(0, we0, re0, sx0, sy0, wd0, rv0, rdd0, idl0);
        check_inst(1, we1, re1, sx1, sy1, wd1, rv1, rdd1, idl1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        chk("rst_wr_gnt", 32'(wg0 | wg1), 32'(0));
        chk("rst_rd_gnt", 32'(rg0 | rg1), 32'(0));
        chk("rst_strobes", 32'({we0, re0, we1, re1}), 32'(0));
        chk("rst_rd_valid", 32'({rv0, rv1}), 32'(0));
        chk("rst_idle", 32'({idl0, idl1}), 32'(3));
        rq[0].delete();
        rq[1].delete();
        exp_we  = 1'b0;
        exp_re  = 1'b0;
        pref_wr = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        idle_cycles(2);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_x = '0; wr_y = '0; wr_data = 1'b0;
        rd_x = '0; rd_y = '0;
        @(negedge clk);
        idle_cycles(2);
        n_rst = 1'b1;
        idle_cycles(1);

        // Lone write (3,-2)=1
        wr_req = 1'b1; wr_x = 4'd3; wr_y = 4'(-2); wr_data = 1'b1;
        cycle();
        wr_req = 1'b0;
        idle_cycles(2);

        // Contention from reset: W,R,W,R,W,R with writer advancing on each grant
        do_reset();
        wr_req = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_data = 1'b1;
        rd_req = 1'b1; rd_x = 4'd1; rd_y = 4'd1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_gw) begin
                wr_x = wr_x + 4'd1;
                wr_data = ~wr_data;
            end else begin
                rd_x = rd_x + 4'd1;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        idle_cycles(6);

        // Lone read of the first write
        rd_req = 1'b1; rd_x = 4'd3; rd_y = 4'(-2);
        cycle();
        rd_req = 1'b0;
        idle_cycles(6);

        // Read-after-write to (2,2): write 1, read; then write 0, read
        for (int v = 1; v >= 0; v--) begin
            wr_req = 1'b1; wr_x = 4'd2; wr_y = 4'd2; wr_data = 1'(v);
            cycle();
            wr_req = 1'b0;
            rd_req = 1'b1; rd_x = 4'd2; rd_y = 4'd2;
            cycle();
            rd_req = 1'b0;
            idle_cycles(6);
        end

        // Fill (k,-k) with a pattern, then stream 8 reads back-to-back
        wr_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_x = 4'(k); wr_y = 4'(-k); wr_data = 1'(k % 3 != 0);
            cycle();
        end
        wr_req = 1'b0;
        rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_x = 4'(k); rd_y = 4'(-k);
            cycle();
        end
        rd_req = 1'b0;
        idle_cycles(8);

        // Reset in the middle of a read burst: in-flight reads are dropped
        rd_req = 1'b1;
        for (int k = 1; k < 4; k++) begin
            rd_x = 4'(k); rd_y = 4'(-k);
            cycle();
        end
        do_reset();
        idle_cycles(LAT1 + 2);

        // Normal operation after reset
        rd_req = 1'b1; rd_x = 4'd4; rd_y = 4'(-4);
        cycle();
        rd_req = 1'b0;
        idle_cycles(7);
        chk("u0_drain", 32'(rq[0].size()), 32'(0));
        chk("u1_drain", 32'(rq[1].size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
